// File: rtl/counter_ctrl_pkg.sv
// Shared types, constants and helpers for the counter button control stage.
package counter_ctrl_pkg;

  // Repeat FSM state encoding for the up/down buttons.
  typedef logic [1:0] rpt_state_t;
  localparam rpt_state_t RptIdle   = 2'd0;
  localparam rpt_state_t RptDelay  = 2'd1;
  localparam rpt_state_t RptRepeat = 2'd2;

  // Winning request after arbitration; load beats up beats down.
  typedef logic [1:0] req_sel_t;
  localparam req_sel_t ReqNone = 2'd0;
  localparam req_sel_t ReqLoad = 2'd1;
  localparam req_sel_t ReqUp   = 2'd2;
  localparam req_sel_t ReqDown = 2'd3;

  // Bits needed to hold any value in [0, max_val]; never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val < 2) begin
      w = 1;
    end else begin
      w = int'($clog2(max_val + 1));
    end
    return w;
  endfunction

  // Fixed-priority pick; lower-priority requests in the same cycle are dropped.
  function automatic req_sel_t arbitrate(input logic load_req, input logic up_req,
                                         input logic down_req);
    req_sel_t sel;
    if (load_req) begin
      sel = ReqLoad;
    end else if (up_req) begin
      sel = ReqUp;
    end else if (down_req) begin
      sel = ReqDown;
    end else begin
      sel = ReqNone;
    end
    return sel;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One raw push-button in, one single-cycle request out.
// Two-flop synchronizer, saturating debounce counter, rising-edge detect and an
// optional hold-to-repeat FSM.
module btn_conditioner
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic req_o
);

  localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RpW   = cnt_width(RpMax);

  localparam logic [DbW-1:0] DbLimit    = DbW'(DEBOUNCE_CYCLES);
  localparam logic [RpW-1:0] DelayLast  = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0] PeriodLast = RpW'(REPEAT_PERIOD - 1);

  logic           sync1_q, sync2_q;
  logic           level_q, level_d;
  logic           prev_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  rpt_state_t     state_q, state_d;
  logic [RpW-1:0] rp_cnt_q, rp_cnt_d;
  logic           rise;
  logic           rpt_req;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level flips only once the counter has already reached the limit,
  // so a change needs DEBOUNCE_CYCLES differing samples plus the flip cycle.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q >= DbLimit) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Debounced level, its one-cycle delayed copy and the debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= 1'b0;
      prev_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      prev_q   <= level_q;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign rise = level_q & ~prev_q;

  // Repeat FSM: release is checked before the count so a release never fires a pulse.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    rpt_req  = 1'b0;
    case (state_q)
      RptIdle: begin
        rp_cnt_d = '0;
        if (rise && REPEAT_EN) begin
          state_d = RptDelay;
        end
      end
      RptDelay: begin
        if (!level_q) begin
          state_d  = RptIdle;
          rp_cnt_d = '0;
        end else if (rp_cnt_q >= DelayLast) begin
          rpt_req  = 1'b1;
          state_d  = RptRepeat;
          rp_cnt_d = '0;
        end else begin
          rp_cnt_d = rp_cnt_q + RpW'(1);
        end
      end
      RptRepeat: begin
        if (!level_q) begin
          state_d  = RptIdle;
          rp_cnt_d = '0;
        end else if (rp_cnt_q >= PeriodLast) begin
          rpt_req  = 1'b1;
          rp_cnt_d = '0;
        end else begin
          rp_cnt_d = rp_cnt_q + RpW'(1);
        end
      end
      default: begin
        state_d  = RptIdle;
        rp_cnt_d = '0;
      end
    endcase
  end

  // Repeat FSM state and its delay/period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RptIdle;
      rp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

  assign req_o = rise | rpt_req;

endmodule

// File: rtl/counter_button_ctrl.sv
// Control stage in front of the up/down/load counter: conditions the three buttons,
// synchronizes the switch bank, arbitrates requests and registers the strobes.
module counter_button_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_load,
  input  logic [N-1:0] sw_d,
  output logic         enable,
  output logic         up,
  output logic         load,
  output logic [N-1:0] d
);

  logic [N-1:0] sw_sync1_q, sw_sync2_q;
  logic         up_req, down_req, load_req;
  req_sel_t     req_sel;
  logic         enable_q, enable_d;
  logic         up_q, up_d;
  logic         load_q, load_d;
  logic [N-1:0] d_q, d_d;

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= sw_d;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_cond_up (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_up),
    .req_o (up_req)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b1)
  ) u_cond_down (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_down),
    .req_o (down_req)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_cond_load (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_load),
    .req_o (load_req)
  );

  assign req_sel = arbitrate(load_req, up_req, down_req);

  // Next output values: strobes default low, direction and load value hold.
  always_comb begin
    enable_d = 1'b0;
    load_d   = 1'b0;
    up_d     = up_q;
    d_d      = d_q;
    case (req_sel)
      ReqLoad: begin
        enable_d = 1'b1;
        load_d   = 1'b1;
        d_d      = sw_sync2_q;
      end
      ReqUp: begin
        enable_d = 1'b1;
        up_d     = 1'b1;
      end
      ReqDown: begin
        enable_d = 1'b1;
        up_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers driving the counter directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      up_q     <= 1'b1;
      load_q   <= 1'b0;
      d_q      <= '0;
    end else begin
      enable_q <= enable_d;
      up_q     <= up_d;
      load_q   <= load_d;
      d_q      <= d_d;
    end
  end

  assign enable = enable_q;
  assign up     = up_q;
  assign load   = load_q;
  assign d      = d_q;

endmodule

// File: tb/tb_counter_button_ctrl.sv
// Directed bench for counter_button_ctrl with short debounce/repeat timings.
module tb_counter_button_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned Db = 4;
  localparam int unsigned Rd = 20;
  localparam int unsigned Rp = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_load = 1'b0;
  logic [N-1:0] sw_d = '0;
  logic         enable, up, load;
  logic [N-1:0] d;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;

  always #5 clk = ~clk;

  counter_button_ctrl #(
    .N               (N),
    .DEBOUNCE_CYCLES (Db),
    .REPEAT_DELAY    (Rd),
    .REPEAT_PERIOD   (Rp)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .sw_d     (sw_d),
    .enable   (enable),
    .up       (up),
    .load     (load),
    .d        (d)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n_en;
    n_en = 0;
    #1 reset = 1'b1;
    #1;
    chk_cnt++;
    if (enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", enable);
    else pass_cnt++;
    chk_cnt++;
    if (up !== 1'b1) $display("FAIL reset_up: got %b want 1", up);
    else pass_cnt++;
    chk_cnt++;
    if (load !== 1'b0) $display("FAIL reset_load: got %b want 0", load);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 4'h0) $display("FAIL reset_d: got %h want 0", d);
    else pass_cnt++;
    repeat (3) step();
    reset = 1'b0;
    repeat (20) begin
      step();
      if (enable === 1'b1) n_en++;
    end
    chk_cnt++;
    if (n_en != 0) $display("FAIL reset_idle_strobes: got %0d want 0", n_en);
    else pass_cnt++;
  endtask

  task automatic test_clean_press();
    int   n_en, first, n_rel;
    logic up_at, load_at;
    n_en = 0; first = -1; n_rel = 0; up_at = 1'bx; load_at = 1'bx;
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (enable === 1'b1) begin
        n_en++;
        if (first < 0) begin
          first = i; up_at = up; load_at = load;
        end
      end
    end
    btn_up = 1'b0;
    repeat (30) begin
      step();
      if (enable === 1'b1) n_rel++;
    end
    chk_cnt++;
    if (n_en != 1) $display("FAIL press_count: got %0d want 1", n_en);
    else pass_cnt++;
    chk_cnt++;
    if (first != 8) $display("FAIL press_latency: got step %0d want 8", first);
    else pass_cnt++;
    chk_cnt++;
    if (up_at !== 1'b1) $display("FAIL press_up: got %b want 1", up_at);
    else pass_cnt++;
    chk_cnt++;
    if (load_at !== 1'b0) $display("FAIL press_load: got %b want 0", load_at);
    else pass_cnt++;
    chk_cnt++;
    if (n_rel != 0) $display("FAIL press_release: got %0d strobes want 0", n_rel);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int   n_tog, n_en, first, n_rel;
    logic up_at, load_at;
    n_tog = 0; n_en = 0; first = -1; n_rel = 0; up_at = 1'bx; load_at = 1'bx;
    for (int i = 0; i < 16; i++) begin
      btn_down = ((i / 2) % 2) == 0;
      step();
      if (enable === 1'b1) n_tog++;
    end
    btn_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (enable === 1'b1) begin
        n_en++;
        if (first < 0) begin
          first = i; up_at = up; load_at = load;
        end
      end
    end
    btn_down = 1'b0;
    repeat (30) begin
      step();
      if (enable === 1'b1) n_rel++;
    end
    chk_cnt++;
    if (n_tog != 0) $display("FAIL bounce_toggle: got %0d strobes want 0", n_tog);
    else pass_cnt++;
    chk_cnt++;
    if (n_en != 1) $display("FAIL bounce_count: got %0d want 1", n_en);
    else pass_cnt++;
    chk_cnt++;
    if (first != 8) $display("FAIL bounce_latency: got step %0d want 8", first);
    else pass_cnt++;
    chk_cnt++;
    if (up_at !== 1'b0) $display("FAIL bounce_dir: got up=%b want 0", up_at);
    else pass_cnt++;
    chk_cnt++;
    if (load_at !== 1'b0) $display("FAIL bounce_load: got %b want 0", load_at);
    else pass_cnt++;
    chk_cnt++;
    if (n_rel != 0) $display("FAIL bounce_release: got %0d strobes want 0", n_rel);
    else pass_cnt++;
  endtask

  task automatic test_load();
    int         n_en, first, n_rel;
    logic       up_at, load_at;
    logic [3:0] d_at;
    n_en = 0; first = -1; n_rel = 0; up_at = 1'bx; load_at = 1'bx; d_at = 'x;
    sw_d = 4'hA;
    repeat (3) step();
    btn_load = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (enable === 1'b1) begin
        n_en++;
        if (first < 0) begin
          first = i; up_at = up; load_at = load; d_at = d;
        end
      end
    end
    btn_load = 1'b0;
    repeat (30) begin
      step();
      if (enable === 1'b1) n_rel++;
    end
    chk_cnt++;
    if (n_en != 1) $display("FAIL load_count: got %0d want 1", n_en);
    else pass_cnt++;
    chk_cnt++;
    if (first != 8) $display("FAIL load_latency: got step %0d want 8", first);
    else pass_cnt++;
    chk_cnt++;
    if (load_at !== 1'b1) $display("FAIL load_flag: got %b want 1", load_at);
    else pass_cnt++;
    chk_cnt++;
    if (d_at !== 4'hA) $display("FAIL load_d: got %h want a", d_at);
    else pass_cnt++;
    chk_cnt++;
    if (up_at !== 1'b0) $display("FAIL load_up_hold: got %b want 0", up_at);
    else pass_cnt++;
    chk_cnt++;
    if (n_rel != 0) $display("FAIL load_release: got %0d strobes want 0", n_rel);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 4'hA) $display("FAIL load_d_hold: got %h want a", d);
    else pass_cnt++;
  endtask

  task automatic test_auto_repeat();
    int   n_en, n_rel;
    int   idx[8];
    int   exp_idx[6] = '{8, 28, 36, 44, 52, 60};
    logic all_up;
    n_en = 0; n_rel = 0; all_up = 1'b1;
    for (int k = 0; k < 8; k++) idx[k] = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (enable === 1'b1) begin
        if (n_en < 8) idx[n_en] = i;
        n_en++;
        if (up !== 1'b1 || load !== 1'b0) all_up = 1'b0;
      end
    end
    btn_up = 1'b0;
    repeat (40) begin
      step();
      if (enable === 1'b1) n_rel++;
    end
    chk_cnt++;
    if (n_en != 6) $display("FAIL repeat_count: got %0d want 6", n_en);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      chk_cnt++;
      if (idx[k] != exp_idx[k])
        $display("FAIL repeat_pulse%0d: got step %0d want %0d", k, idx[k], exp_idx[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (all_up !== 1'b1) $display("FAIL repeat_dir: got %b want 1", all_up);
    else pass_cnt++;
    chk_cnt++;
    if (n_rel != 0) $display("FAIL repeat_release: got %0d strobes want 0", n_rel);
    else pass_cnt++;
  endtask

  task automatic test_priority_reset();
    int         n_en, first, n_post;
    logic       load_at, en36, load36;
    logic [3:0] d_at;
    logic       up_post;
    n_en = 0; first = -1; n_post = 0; load_at = 1'bx; d_at = 'x; up_post = 1'bx;
    en36 = 1'bx; load36 = 1'bx;
    sw_d = 4'h5;
    repeat (3) step();
    btn_load = 1'b1;
    btn_up   = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      step();
      if (i == 13) btn_load = 1'b0;
      if (i <= 12 && enable === 1'b1) begin
        n_en++;
        if (first < 0) begin
          first = i; load_at = load; d_at = d;
        end
      end
      if (i == 36) begin
        en36 = enable; load36 = load;
      end
    end
    chk_cnt++;
    if (n_en != 1) $display("FAIL prio_count: got %0d want 1", n_en);
    else pass_cnt++;
    chk_cnt++;
    if (first != 8) $display("FAIL prio_latency: got step %0d want 8", first);
    else pass_cnt++;
    chk_cnt++;
    if (load_at !== 1'b1) $display("FAIL prio_load: got %b want 1", load_at);
    else pass_cnt++;
    chk_cnt++;
    if (d_at !== 4'h5) $display("FAIL prio_d: got %h want 5", d_at);
    else pass_cnt++;
    chk_cnt++;
    if (en36 !== 1'b1 || load36 !== 1'b0)
      $display("FAIL prio_up_repeat: got en=%b load=%b want en=1 load=0", en36, load36);
    else pass_cnt++;
    // Reset lands in the middle of an up strobe while the up button sits in REPEAT.
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (enable !== 1'b0) $display("FAIL midreset_enable: got %b want 0", enable);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 4'h0) $display("FAIL midreset_d: got %h want 0", d);
    else pass_cnt++;
    chk_cnt++;
    if (up !== 1'b1 || load !== 1'b0)
      $display("FAIL midreset_ctrl: got up=%b load=%b want up=1 load=0", up, load);
    else pass_cnt++;
    repeat (2) step();
    reset = 1'b0;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (enable === 1'b1) begin
        n_post++;
        if (first < 0) begin
          first = i; up_post = up;
        end
      end
    end
    btn_up = 1'b0;
    repeat (30) step();
    chk_cnt++;
    if (n_post != 1) $display("FAIL postreset_count: got %0d want 1", n_post);
    else pass_cnt++;
    chk_cnt++;
    if (first != 8) $display("FAIL postreset_latency: got step %0d want 8", first);
    else pass_cnt++;
    chk_cnt++;
    if (up_post !== 1'b1) $display("FAIL postreset_up: got %b want 1", up_post);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_load();
    test_auto_repeat();
    test_priority_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
